adder_packet_scheduler: RTL and testbench

ADDER_PACKET_SCHEDULER -- requirements
Module: adder_packet_scheduler

---
 rtl/adder_packet_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_adder_packet_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_packet_scheduler.sv
// adder_packet_scheduler
//
// Purpose: accepts 64-bit add requests from two requesters with round-robin
// arbitration. Each packet is added SLICE_W bits per cycle with a rippled carry,
// and the result is presented with a valid/ready handshake.
//
// Ports:
//   clk, rst_n                     - rising-edge clock, asynchronous active-low reset
//   req0_valid/req0_packet/req0_ready - requester 0 handshake and packet
//                                       ([151:136] tag, [135:72] A, [71:8] B, [7:0] unused)
//   req1_valid/req1_packet/req1_ready - requester 1, same layout
//   res_valid/res_ready            - result handshake
//   res_sum, res_co                - (A+B) mod 2^64 and carry out of bit 63
//   res_tag, res_src               - tag and requester index of the result
//   busy                           - high whenever the scheduler is not idle
module adder_packet_scheduler #(
  parameter int SLICE_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [151:0] req0_packet,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [151:0] req1_packet,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [63:0]  res_sum,
  output logic         res_co,
  output logic [15:0]  res_tag,
  output logic         res_src,
  output logic         busy
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t              state_q;
  logic                rrPtr_q;
  logic [63:0]         opA_q;
  logic [63:0]         opB_q;
  logic [63:0]         sumAcc_q;
  logic [15:0]         tag_q;
  logic                src_q;
  logic [CNT_W-1:0]    sliceCnt_q;
  logic                carry_q;
  logic                resValid_q;
  logic [63:0]         resSum_q;
  logic                resCo_q;
  logic [15:0]         resTag_q;
  logic                resSrc_q;
  logic                busy_q;

  logic                grant0;
  logic                grant1;
  logic                accept;
  logic [151:0]        acceptPkt;
  logic [6:0]          sliceBase;
  logic [SLICE_W-1:0]  aSlice;
  logic [SLICE_W-1:0]  bSlice;
  logic [SLICE_W:0]    sliceAdd;
  logic [63:0]         sliceMask;
  logic [63:0]         sumMerged;
  logic                lastSlice;
  logic                unusedPktBits;

  // Arbitration is only live in IDLE. A lone valid wins outright; on a tie the
  // round-robin pointer names the requester that was not served last, so the
  // two ready signals can never be high together.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rrPtr_q;
        grant1 = rrPtr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acceptPkt  = grant1 ? req1_packet : req0_packet;

  // The low byte of each packet carries nothing for this block; folding it
  // into a dedicated signal documents that it is deliberately discarded.
  assign unusedPktBits = ^{req0_packet[7:0], req1_packet[7:0]};

  // Slice datapath: pick slice k of both operands by shifting, add it with the
  // carry register, and splice the slice result into the running sum without
  // disturbing the slices already computed.
  always_comb begin
    sliceBase = 7'(sliceCnt_q) * 7'(SLICE_W);
    aSlice    = SLICE_W'(opA_q >> sliceBase);
    bSlice    = SLICE_W'(opB_q >> sliceBase);
    sliceAdd  = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE_W{1'b0}}, carry_q};
    sliceMask = 64'({SLICE_W{1'b1}});
    sumMerged = (sumAcc_q & ~(sliceMask << sliceBase)) |
                (64'(sliceAdd[SLICE_W-1:0]) << sliceBase);
    lastSlice = (sliceCnt_q == CNT_W'(NSLICE - 1));
  end

  // Main FSM with all result outputs registered. The res_* registers are only
  // loaded on the ADD->DONE edge so they hold the previous result through IDLE
  // and ADD; partial sums live in sumAcc_q instead. Reset drops any operation
  // in flight, so an aborted packet is simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= 1'b0;
      opA_q      <= '0;
      opB_q      <= '0;
      sumAcc_q   <= '0;
      tag_q      <= '0;
      src_q      <= 1'b0;
      sliceCnt_q <= '0;
      carry_q    <= 1'b0;
      resValid_q <= 1'b0;
      resSum_q   <= '0;
      resCo_q    <= 1'b0;
      resTag_q   <= '0;
      resSrc_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opA_q      <= acceptPkt[135:72];
            opB_q      <= acceptPkt[71:8];
            tag_q      <= acceptPkt[151:136];
            src_q      <= grant1;
            rrPtr_q    <= ~grant1;
            sliceCnt_q <= '0;
            carry_q    <= 1'b0;
            sumAcc_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= ADD;
          end
        end
        ADD: begin
          sumAcc_q   <= sumMerged;
          carry_q    <= sliceAdd[SLICE_W];
          sliceCnt_q <= sliceCnt_q + CNT_W'(1);
          if (lastSlice) begin
            resSum_q   <= sumMerged;
            resCo_q    <= sliceAdd[SLICE_W];
            resTag_q   <= tag_q;
            resSrc_q   <= src_q;
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = resValid_q;
  assign res_sum   = resSum_q;
  assign res_co    = resCo_q;
  assign res_tag   = resTag_q;
  assign res_src   = resSrc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_packet_scheduler.sv
// tb_adder_packet_scheduler
//
// Purpose: self-checking bench for adder_packet_scheduler. A 16-bit-slice
// instance is driven with directed and random packets and compared against a
// plain-arithmetic model (65-bit add, "serve the other requester on a tie"
// arbitration). A second instance with 64-bit slices covers the one-cycle case.
module tb_adder_packet_scheduler;

  localparam int SLICE_W_TB = 16;
  localparam int LAT        = 64 / SLICE_W_TB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0Valid, req1Valid, req0Ready, req1Ready;
  logic [151:0] req0Packet, req1Packet;
  logic         resValid, resReady, resCo, resSrc, busy;
  logic [63:0]  resSum;
  logic [15:0]  resTag;

  logic         wReq0Valid, wReq1Valid, wReq0Ready, wReq1Ready;
  logic [151:0] wReq0Packet, wReq1Packet;
  logic         wResValid, wResReady, wResCo, wResSrc, wBusy;
  logic [63:0]  wResSum;
  logic [15:0]  wResTag;

  int           compareCount = 0;
  int           mismatchCount = 0;
  int           lastSrc;
  logic [63:0]  prevSum;
  logic         prevCo;
  logic [15:0]  prevTag;
  logic         prevSrc;

  // Free-running 100 MHz clock shared by both instances.
  always #5 clk = ~clk;

  adder_packet_scheduler #(.SLICE_W(SLICE_W_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_packet(req0Packet), .req0_ready(req0Ready),
    .req1_valid(req1Valid), .req1_packet(req1Packet), .req1_ready(req1Ready),
    .res_valid(resValid), .res_ready(resReady), .res_sum(resSum),
    .res_co(resCo), .res_tag(resTag), .res_src(resSrc), .busy(busy)
  );

  adder_packet_scheduler #(.SLICE_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(wReq0Valid), .req0_packet(wReq0Packet), .req0_ready(wReq0Ready),
    .req1_valid(wReq1Valid), .req1_packet(wReq1Packet), .req1_ready(wReq1Ready),
    .res_valid(wResValid), .res_ready(wResReady), .res_sum(wResSum),
    .res_co(wResCo), .res_tag(wResTag), .res_src(wResSrc), .busy(wBusy)
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge so outputs have settled.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one arbitration round, follow the winning packet to its result,
  // optionally stall the consumer for holdCycles, and check everything
  // against the model.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [63:0] a0, input logic [63:0] b0, input logic [15:0] t0,
                               input logic [63:0] a1, input logic [63:0] b1, input logic [15:0] t1,
                               input int holdCycles, input bit keepValid);
    int          grant;
    int          lat;
    bit          gotIt;
    logic [63:0] expA, expB;
    logic [15:0] expT;
    logic [64:0] full;
    req0Packet = {t0, a0, b0, 8'($urandom)};
    req1Packet = {t1, a1, b1, 8'($urandom)};
    req0Valid  = v0;
    req1Valid  = v1;
    resReady   = 1'b0;
    if (v0 && v1) grant = (lastSrc == 0) ? 1 : 0;
    else          grant = v0 ? 0 : 1;
    expA = (grant == 0) ? a0 : a1;
    expB = (grant == 0) ? b0 : b1;
    expT = (grant == 0) ? t0 : t1;
    full = {1'b0, expA} + {1'b0, expB};
    #1;
    checkOutput("ready0", 64'(req0Ready), 64'(grant == 0));
    checkOutput("ready1", 64'(req1Ready), 64'(grant == 1));
    checkOutput("readyBoth", 64'(req0Ready & req1Ready), 64'(0));
    tick;
    lastSrc = grant;
    if (!keepValid) begin
      req0Valid = 1'b0;
      req1Valid = 1'b0;
    end
    checkOutput("busyInAdd", 64'(busy), 64'(1));
    checkOutput("validInAdd", 64'(resValid), 64'(0));
    checkOutput("readyInAdd", 64'(req0Ready | req1Ready), 64'(0));
    checkOutput("sumHeldInAdd", resSum, prevSum);
    lat   = 0;
    gotIt = 1'b0;
    while (!gotIt && lat < 20) begin
      tick;
      lat++;
      if (resValid) gotIt = 1'b1;
    end
    checkOutput("latency", 64'(lat), 64'(LAT));
    if (!gotIt) return;
    checkOutput("sum", resSum, full[63:0]);
    checkOutput("co", 64'(resCo), 64'(full[64]));
    checkOutput("tag", 64'(resTag), 64'(expT));
    checkOutput("src", 64'(resSrc), 64'(grant));
    for (int h = 0; h < holdCycles; h++) begin
      tick;
      checkOutput("holdValid", 64'(resValid), 64'(1));
      checkOutput("holdSum", resSum, full[63:0]);
      checkOutput("holdTag", 64'(resTag), 64'(expT));
      checkOutput("holdBusy", 64'(busy), 64'(1));
      checkOutput("holdReady", 64'(req0Ready | req1Ready), 64'(0));
    end
    resReady = 1'b1;
    tick;
    resReady = 1'b0;
    checkOutput("validAfterDone", 64'(resValid), 64'(0));
    checkOutput("busyAfterDone", 64'(busy), 64'(0));
    checkOutput("sumHeldIdle", resSum, full[63:0]);
    checkOutput("srcHeldIdle", 64'(resSrc), 64'(grant));
    prevSum = full[63:0];
    prevCo  = full[64];
    prevTag = expT;
    prevSrc = grant[0];
  endtask

  // Every result output of the main instance must read zero while in reset.
  task automatic checkResetOutputs(input string where);
    checkOutput({where, "Valid"}, 64'(resValid), 64'(0));
    checkOutput({where, "Sum"}, resSum, 64'(0));
    checkOutput({where, "Co"}, 64'(resCo), 64'(0));
    checkOutput({where, "Tag"}, 64'(resTag), 64'(0));
    checkOutput({where, "Src"}, 64'(resSrc), 64'(0));
    checkOutput({where, "Busy"}, 64'(busy), 64'(0));
  endtask

  // Test sequence: reset, directed corner cases, random traffic, reset abort,
  // then the single-slice instance.
  initial begin
    logic        v0, v1;
    logic [63:0] a0, b0, a1, b1;
    rst_n      = 1'b1;
    req0Valid  = 1'b0; req1Valid = 1'b0; resReady = 1'b0;
    req0Packet = '0;   req1Packet = '0;
    wReq0Valid = 1'b0; wReq1Valid = 1'b0; wResReady = 1'b0;
    wReq0Packet = '0;  wReq1Packet = '0;
    lastSrc = 1; prevSum = '0; prevCo = 1'b0; prevTag = '0; prevSrc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    checkOutput("resetW64Valid", 64'(wResValid), 64'(0));
    tick;
    tick;
    rst_n = 1'b0;
    checkResetOutputs("resetClocked");
    rst_n = 1'b1;

    $display("[TB] both requesters continuously valid from reset");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 64'(i + 1), 64'(100), 16'(16'h0100 + i),
                    64'(i + 50), 64'(200), 16'(16'h0200 + i), 0, 1'b1);
    req0Valid = 1'b0;
    req1Valid = 1'b0;

    $display("[TB] directed carry cases");
    applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'h00A5, '0, '0, '0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 16'h1234, '0, '0, '0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, '0, '0, 64'h8000_0000_FFFF_0000, 64'h8000_0000_0001_0000,
                  16'hBEEF, 5, 1'b0);

    $display("[TB] valid pulse that never meets a clock edge");
    #1 req0Valid = 1'b1;
    #2 req0Valid = 1'b0;
    tick;
    checkOutput("glitchBusy", 64'(busy), 64'(0));

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b0 = ~a0 + 64'(i % 2);
      applyStimulus(v0, v1, a0, b0, 16'($urandom), a1, b1, 16'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;

    $display("[TB] reset during ADD");
    applyStimulus(1'b1, 1'b0, 64'd7, 64'd9, 16'h0007, '0, '0, '0, 0, 1'b0);
    req0Packet = {16'h0BAD, 64'hFFFF_0000_FFFF_0000, 64'h1111_1111_1111_1111, 8'h00};
    req0Valid  = 1'b1;
    tick;
    req0Valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    tick;
    rst_n = 1'b1;
    lastSrc = 1; prevSum = '0; prevCo = 1'b0; prevTag = '0; prevSrc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      checkOutput("noReissueValid", 64'(resValid), 64'(0));
      checkOutput("noReissueBusy", 64'(busy), 64'(0));
    end
    applyStimulus(1'b1, 1'b1, 64'd3, 64'd5, 16'h0035, 64'd40, 64'd2, 16'h0402, 0, 1'b0);

    $display("[TB] single-slice instance");
    wReq0Packet = {16'h0038, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h5A};
    wReq0Valid  = 1'b1;
    #1;
    checkOutput("w64Ready", 64'(wReq0Ready), 64'(1));
    tick;
    wReq0Valid = 1'b0;
    checkOutput("w64ValidEarly", 64'(wResValid), 64'(0));
    tick;
    checkOutput("w64Valid", 64'(wResValid), 64'(1));
    checkOutput("w64Sum", wResSum, 64'(0));
    checkOutput("w64Co", 64'(wResCo), 64'(1));
    checkOutput("w64Tag", 64'(wResTag), 64'(16'h0038));
    wResReady = 1'b1;
    tick;
    wResReady = 1'b0;
    checkOutput("w64ValidDone", 64'(wResValid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
